// File: rtl/demux5x16_16_buf_if.sv
// Producer/consumer bundle for the 1-to-5 buffered word distributor.
interface demux5x16_16_buf_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;
  logic [WIDTH-1:0] out_data4;
  logic [4:0]       out_valid;
  logic [4:0]       out_ready;
  logic             sel_err;
  logic [7:0]       drop_count;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data0, out_data1, out_data2, out_data3, out_data4,
           out_valid, sel_err, drop_count
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data0, out_data1, out_data2, out_data3, out_data4,
           out_valid, sel_err, drop_count
  );
endinterface

// File: rtl/demux5x16_16_buf.sv
// Buffered 1-to-5 word distributor: one producer, five FIFO-backed consumers.
// Illegal selects (5..7) are accepted, dropped, flagged and counted.

// Per-port FIFO lane: DEPTH words, wrap-around pointers, occupancy count.
module demux5x16_16_buf_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    cnt
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wp, rp;

  // Storage, pointers and count; push+pop together leaves cnt unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= '0;
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= wdata;
        wp      <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  assign rdata = mem[rp];
endmodule

module demux5x16_16_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input logic                clk,
  input logic                reset,
  demux5x16_16_buf_if.slave  bus
);
  localparam int NP = 5;
  localparam int CW = $clog2(DEPTH + 1);

  logic [NP-1:0][WIDTH-1:0] rdata;
  logic [NP-1:0][CW-1:0]    cnt;
  logic [NP-1:0]            vld, push, pop;
  logic                     legal, rdy;

  assign legal = (bus.in_sel < 3'd5);

  // Ready from the addressed port only; a full port still accepts when it
  // pops this same cycle. Illegal selects are always accepted (and dropped).
  always_comb begin
    rdy = 1'b1;
    for (int n = 0; n < NP; n++)
      if (legal && bus.in_sel == 3'(n))
        rdy = (cnt[n] < CW'(DEPTH)) || bus.out_ready[n];
  end

  assign bus.in_ready = rdy;

  for (genvar gi = 0; gi < NP; gi++) begin : g_port
    assign vld[gi]  = (cnt[gi] != '0);
    assign pop[gi]  = vld[gi] && bus.out_ready[gi];
    assign push[gi] = bus.in_valid && rdy && legal && (bus.in_sel == 3'(gi));

    demux5x16_16_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[gi]),
      .pop   (pop[gi]),
      .wdata (bus.in_data),
      .rdata (rdata[gi]),
      .cnt   (cnt[gi])
    );
  end

  assign bus.out_valid = vld;
  assign bus.out_data0 = rdata[0];
  assign bus.out_data1 = rdata[1];
  assign bus.out_data2 = rdata[2];
  assign bus.out_data3 = rdata[3];
  assign bus.out_data4 = rdata[4];

  // Drop flag pulses the cycle after an illegal accept; count saturates at 255.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.sel_err    <= 1'b0;
      bus.drop_count <= '0;
    end else begin
      bus.sel_err <= bus.in_valid && !legal;
      if (bus.in_valid && !legal && bus.drop_count != 8'hFF)
        bus.drop_count <= bus.drop_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_demux5x16_16_buf.sv
// Self-checking bench: queue-based reference model, directed table, random traffic.
module tb_demux5x16_16_buf;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  demux5x16_16_buf_if #(.WIDTH(16)) bus ();
  demux5x16_16_buf #(.WIDTH(16), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Reference model: one queue per port plus the drop bookkeeping.
  logic [15:0] q [0:4][$];
  int          m_drops;
  logic        m_selerr;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  sel;
    logic        vld;
    logic [4:0]  ordy;
    logic        e_rdy;
    logic [4:0]  e_ov;
    int          e_port;
    logic [15:0] e_data;
  } vec_t;

  vec_t tbl [14];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] od(input int n);
    case (n)
      0: return bus.out_data0;
      1: return bus.out_data1;
      2: return bus.out_data2;
      3: return bus.out_data3;
      default: return bus.out_data4;
    endcase
  endfunction

  function automatic logic model_rdy();
    int s = int'(bus.in_sel);
    if (s > 4) return 1'b1;
    return (q[s].size() < DEPTH) || bus.out_ready[s];
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 5; n++) q[n].delete();
    m_drops  = 0;
    m_selerr = 1'b0;
  endtask

  task automatic model_check();
    logic [4:0] ov;
    ov = '0;
    for (int n = 0; n < 5; n++) ov[n] = (q[n].size() > 0);
    cmp("in_ready", bus.in_ready, model_rdy());
    cmp("out_valid", bus.out_valid, ov);
    cmp("sel_err", bus.sel_err, m_selerr);
    cmp("drop_count", bus.drop_count, m_drops);
    for (int n = 0; n < 5; n++)
      if (q[n].size() > 0) cmp($sformatf("out_data%0d", n), od(n), q[n][0]);
  endtask

  // Apply one edge to the model with the inputs currently driven.
  task automatic model_update();
    logic r;
    int   s;
    r = model_rdy();
    s = int'(bus.in_sel);
    for (int n = 0; n < 5; n++)
      if (q[n].size() > 0 && bus.out_ready[n]) void'(q[n].pop_front());
    m_selerr = 1'b0;
    if (bus.in_valid && r) begin
      if (s < 5) q[s].push_back(bus.in_data);
      else begin
        m_selerr = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
  endtask

  task automatic pre(input logic [15:0] d, input logic [2:0] s, input logic v, input logic [4:0] r);
    @(negedge clk);
    bus.in_data = d; bus.in_sel = s; bus.in_valid = v; bus.out_ready = r;
    #1;
    model_check();
  endtask

  task automatic post();
    @(posedge clk);
    model_update();
  endtask

  task automatic cyc(input logic [15:0] d, input logic [2:0] s, input logic v, input logic [4:0] r);
    pre(d, s, v, r);
    post();
  endtask

  initial begin
    //         data     sel  vld  ordy      rdy  ov        port data
    tbl[0]  = '{16'h1234, 3'd3, 1'b1, 5'b00000, 1'b1, 5'b00000, 3, 16'h0};
    tbl[1]  = '{16'h5678, 3'd3, 1'b1, 5'b00000, 1'b1, 5'b01000, 3, 16'h1234};
    tbl[2]  = '{16'h0000, 3'd3, 1'b0, 5'b00000, 1'b0, 5'b01000, 3, 16'h1234};
    tbl[3]  = '{16'h0000, 3'd0, 1'b0, 5'b00000, 1'b1, 5'b01000, 3, 16'h1234};
    tbl[4]  = '{16'h0000, 3'd3, 1'b0, 5'b01000, 1'b1, 5'b01000, 3, 16'h1234};
    tbl[5]  = '{16'h0000, 3'd3, 1'b0, 5'b01000, 1'b1, 5'b01000, 3, 16'h5678};
    tbl[6]  = '{16'h0000, 3'd3, 1'b0, 5'b00000, 1'b1, 5'b00000, 3, 16'h0};
    tbl[7]  = '{16'h1111, 3'd2, 1'b1, 5'b00000, 1'b1, 5'b00000, 2, 16'h0};
    tbl[8]  = '{16'h2222, 3'd2, 1'b1, 5'b00000, 1'b1, 5'b00100, 2, 16'h1111};
    tbl[9]  = '{16'hAAAA, 3'd2, 1'b1, 5'b00100, 1'b1, 5'b00100, 2, 16'h1111};
    tbl[10] = '{16'h0000, 3'd2, 1'b0, 5'b00000, 1'b0, 5'b00100, 2, 16'h2222};
    tbl[11] = '{16'h0000, 3'd2, 1'b0, 5'b00100, 1'b1, 5'b00100, 2, 16'h2222};
    tbl[12] = '{16'h0000, 3'd2, 1'b0, 5'b00100, 1'b1, 5'b00100, 2, 16'hAAAA};
    tbl[13] = '{16'h0000, 3'd2, 1'b0, 5'b00000, 1'b1, 5'b00000, 2, 16'h0};

    bus.in_data = '0; bus.in_sel = '0; bus.in_valid = 1'b0; bus.out_ready = '0;
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state: idle outputs and ready for every select.
    for (int s = 0; s < 8; s++) begin
      pre(16'h0, 3'(s), 1'b0, 5'b00000);
      cmp("reset_rdy", bus.in_ready, 1'b1);
      post();
    end
    cmp("reset_ov", bus.out_valid, 5'b0);
    cmp("reset_drop", bus.drop_count, 8'd0);

    // Directed table: port 3 fill/drain and port 2 full push+pop.
    for (int i = 0; i < 14; i++) begin
      pre(tbl[i].data, tbl[i].sel, tbl[i].vld, tbl[i].ordy);
      cmp($sformatf("tbl%0d_rdy", i), bus.in_ready, tbl[i].e_rdy);
      cmp($sformatf("tbl%0d_ov", i), bus.out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov[tbl[i].e_port])
        cmp($sformatf("tbl%0d_data", i), od(tbl[i].e_port), tbl[i].e_data);
      post();
    end

    // Stream 0..9 into port 0 with its consumer always ready.
    for (int i = 0; i < 11; i++) begin
      pre(16'(i), 3'd0, (i < 10), 5'b00001);
      if (i > 0) begin
        cmp("stream_vld", bus.out_valid[0], 1'b1);
        cmp("stream_data", bus.out_data0, 16'(i - 1));
      end
      post();
    end
    cyc(16'h0, 3'd0, 1'b0, 5'b00000);

    // Illegal select: single drop, then saturation.
    cyc(16'hDEAD, 3'd6, 1'b1, 5'b00000);
    pre(16'h0, 3'd0, 1'b0, 5'b00000);
    cmp("ill_selerr", bus.sel_err, 1'b1);
    cmp("ill_drop", bus.drop_count, 8'd1);
    cmp("ill_ov", bus.out_valid, 5'b0);
    post();
    pre(16'h0, 3'd0, 1'b0, 5'b00000);
    cmp("ill_selerr_clr", bus.sel_err, 1'b0);
    post();
    for (int i = 0; i < 300; i++)
      cyc(16'($urandom), 3'($urandom_range(5, 7)), 1'b1, 5'b00000);
    pre(16'h0, 3'd0, 1'b0, 5'b00000);
    cmp("sat_drop", bus.drop_count, 8'd255);
    post();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++)
      cyc(16'($urandom), ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
          1'($urandom), 5'($urandom));
    for (int i = 0; i < 4; i++) cyc(16'h0, 3'd0, 1'b0, 5'b11111);

    // Fill ports 1 and 4, then reset asynchronously between edges.
    cyc(16'h0101, 3'd1, 1'b1, 5'b00000);
    cyc(16'h0102, 3'd1, 1'b1, 5'b00000);
    cyc(16'h0401, 3'd4, 1'b1, 5'b00000);
    cyc(16'h0402, 3'd4, 1'b1, 5'b00000);
    pre(16'h0, 3'd1, 1'b0, 5'b00000);
    cmp("pre_rst_ov", bus.out_valid, 5'b10010);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    cmp("rst_ov", bus.out_valid, 5'b0);
    cmp("rst_data1", bus.out_data1, 16'h0);
    cmp("rst_data4", bus.out_data4, 16'h0);
    cmp("rst_drop", bus.drop_count, 8'd0);
    cmp("rst_rdy", bus.in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    cyc(16'hBEEF, 3'd1, 1'b1, 5'b00000);
    pre(16'h0, 3'd0, 1'b0, 5'b00000);
    cmp("post_rst_ov", bus.out_valid, 5'b00010);
    cmp("post_rst_data", bus.out_data1, 16'hBEEF);
    post();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
